bus_cycle_sequencer: RTL and testbench
======================================

Name: bus_cycle_sequencer

Overview:
- Sequences the shared C64 address/data bus on every phi cycle.
- Generates the phi clock, DRAM RAS/CAS and the row/column address mux select.
- Drives the tri-state enables for the address and data buses, and the '245 transceiver direction.
- Arbitrates phi-high bus ownership between the CPU (register access, normal cycles) and VIC DMA (badline/sprite stolen cycles) using BA/AEC.
- Sits between the clock generator (clk_dot4x) and the vicii core's fetch/register logic.

Parameters:
- RAS_FALL, 4, phase tick within a half-cycle at which ras goes low.
- MUX_COL, 6, tick at which addr_mux switches from row to column.
- CAS_FALL, 7, tick at which cas goes low.
- CAPTURE, 13, tick of the one-tick vic_capture pulse (VIC latches dbi).
- BA_LEAD, 3, number of phi cycles that BA is low before AEC is stolen.

Ports:
- clk_dot4x  in  1  4x dot clock; 32 ticks per phi period.
- rst  in  1  reset, asynchronous, active-high.
- dma_req  in  1  VIC requests phi-high bus for coming cycle(s); sampled at phase 0.
- ce  in  1  chip enable, active low.
- rw  in  1  1=read, 0=write.
- clk_phi  out  1  CPU phi clock; 0 for phase 0..15, 1 for phase 16..31.
- phase  out  5  current tick within phi period.
- ba  out  1  bus available, active low.
- aec  out  1  1=CPU owns bus, 0=VIC owns bus.
- ras  out  1  DRAM row strobe, active low.
- cas  out  1  DRAM column strobe, active low.
- addr_mux  out  1  0=row address, 1=column address.
- vic_write_ab  out  1  VIC drives the address bus.
- vic_write_db  out  1  VIC drives the data bus (register read).
- ls245_data_dir  out  1  1=VIC to CPU bus, 0=CPU bus to VIC.
- vic_capture  out  1  one-tick strobe: latch fetched data.
- reg_wr_strobe  out  1  one-tick strobe: latch CPU register write.
- stolen  out  1  current phi-high half is a VIC stolen cycle.

Behaviour:
- Reset values:
  - phase=0, clk_phi=0, ba=1, aec=0.
  - ras=1, cas=1, addr_mux=0.
  - vic_write_ab=0, vic_write_db=0, ls245_data_dir=0.
  - vic_capture=0, reg_wr_strobe=0, stolen=0.
  - Arbiter in IDLE.
- Reset asserted mid-cycle forces all of the above immediately, independent of the clock.
- phase: 5-bit free-running counter, increments every clk_dot4x tick, wraps 31 to 0. Let h = phase[3:0].
- Each half-cycle (phi-low always; phi-high when stolen):
  - vic_write_ab=1 for h 1..14.
  - addr_mux=1 for h>=MUX_COL.
  - ras=0 for h>=RAS_FALL.
  - cas=0 for h>=CAS_FALL.
  - vic_capture pulses at h=CAPTURE.
  - All outputs registered; asserted on the tick at which phase equals the stated value.
- phi-high CPU half (not stolen):
  - aec=1, vic_write_ab=0.
  - ras and cas still cycle at the same h offsets (CPU DRAM access).
- Register read: ce=0 and rw=1 sampled at phase 22 -> vic_write_db=1 and ls245_data_dir=1 for phase 24..31, both cleared at phase 0.
- Register write: ce=0 and rw=0 sampled at phase 28 -> reg_wr_strobe pulses at phase 29.
- No register access during a stolen half: ce is ignored when stolen=1.
- aec=0 throughout phi-low.
- Arbiter FSM, evaluated only at phase 0:
  - IDLE: dma_req=1 -> BA_WAIT with cnt=1, ba=0.
  - BA_WAIT: dma_req=0 -> IDLE, ba=1. Otherwise, cnt==BA_LEAD -> STEAL; else cnt++.
  - STEAL: stolen=1 and aec=0 for the whole phi-high half. dma_req=0 at phase 0 -> IDLE, ba=1, stolen=0 starting this cycle.
- Timing consequence: ba falls at least BA_LEAD full phi cycles before the first stolen half.
- dma_req changes between phase-0 samples are ignored.
- Simultaneous dma_req rise and ce access: the CPU access completes in the current cycle; stealing begins no earlier than BA_LEAD cycles later.

Optional Feature:
- Macro BUS_STATS_EN.
- Defined:
  - Adds input stats_clr and output stolen_count[15:0].
  - stolen_count increments at phase 16 of each stolen cycle and saturates at 16'hFFFF.
  - stats_clr is synchronous: clear takes priority over increment on the same tick.
  - stolen_count resets to 0.
- Undefined: ports and counter absent; no other change in behaviour.

Decomposition:
- Package bus_pkg contains:
  - typedef phase_t (logic [4:0]).
  - enum arb_state_t {IDLE, BA_WAIT, STEAL}.
  - Constants REG_RD_SAMPLE=22, REG_RD_START=24, REG_WR_SAMPLE=28.
- Sub-module ba_aec_arbiter: the FSM plus BA_LEAD counter.
  - Inputs: clk_dot4x, rst, phase_zero, dma_req.
  - Outputs: ba, stolen.
- The top level of this block holds the phase counter and strobe decode.

Test Plan:
- Release rst, no requests -> clk_phi toggles every 16 ticks; ras falls at phase 4 and 20, cas at 7 and 23; aec=1 only for phase 16..31; vic_capture at 13.
- ce=0, rw=1 held across phase 22 -> vic_write_db=ls245_data_dir=1 at phase 24..31, 0 at phase 0.
- ce=0, rw=0 at phase 28 -> single reg_wr_strobe at phase 29; no vic_write_db.
- dma_req=1 from cycle 0 -> ba=0 from cycle 0 phase 0; first stolen half (aec=0, vic_write_ab=1 at phase 17..30) in cycle 3; drop dma_req -> ba=1 and aec=1 in that same cycle.
- dma_req pulse 1 cycle, then 0 -> ba low for exactly one cycle, never stolen.
- Assert rst at phase 25 during register read -> vic_write_db, cas and ras inactive immediately; phase=0 after release.
- (BUS_STATS_EN) 5 stolen cycles -> stolen_count=5; stats_clr -> 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and register-access timing points for the bus cycle sequencer.
package bus_pkg;

  typedef logic [4:0] phase_t;

  typedef enum logic [1:0] {
    IDLE,
    BA_WAIT,
    STEAL
  } arb_state_t;

  localparam phase_t REG_RD_SAMPLE = 5'd22;
  localparam phase_t REG_RD_START  = 5'd24;
  localparam phase_t REG_WR_SAMPLE = 5'd28;

endpackage

// File: rtl/bus_cycle_sequencer_arbiter.sv
// BA/AEC arbiter: decides once per phi cycle whether the coming phi-high half
// belongs to the CPU or is stolen by VIC DMA, with BA_LEAD cycles of BA warning.
module ba_aec_arbiter
  import bus_pkg::*;
#(
  parameter int BA_LEAD = 3
) (
  input  logic clk_dot4x,
  input  logic rst,
  input  logic phase_zero,
  input  logic dma_req,
  output logic ba,
  output logic stolen
);

  localparam int CNT_W = (BA_LEAD < 2) ? 1 : $clog2(BA_LEAD + 1);
  localparam logic [CNT_W-1:0] LEAD = CNT_W'(BA_LEAD);

  arb_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  // ba/stolen are registered from the next state so they change exactly at phase 0
  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ba     <= 1'b1;
      stolen <= 1'b0;
    end else if (phase_zero) begin
      state  <= state_n;
      cnt    <= cnt_n;
      ba     <= (state_n == IDLE);
      stolen <= (state_n == STEAL);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (dma_req) begin
          state_n = BA_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      BA_WAIT: begin
        if (!dma_req) begin
          state_n = IDLE;
        end else if (cnt == LEAD) begin
          state_n = STEAL;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STEAL: begin
        if (!dma_req) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Per-phi-cycle bus sequencer: phase counter, DRAM strobes, bus enables and
// register-access strobes. Optional stolen-cycle counter under BUS_STATS_EN.
module bus_cycle_sequencer
  import bus_pkg::*;
#(
  parameter int RAS_FALL = 4,
  parameter int MUX_COL  = 6,
  parameter int CAS_FALL = 7,
  parameter int CAPTURE  = 13,
  parameter int BA_LEAD  = 3
) (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic       dma_req,
  input  logic       ce,
  input  logic       rw,
  output logic       clk_phi,
  output logic [4:0] phase,
  output logic       ba,
  output logic       aec,
  output logic       ras,
  output logic       cas,
  output logic       addr_mux,
  output logic       vic_write_ab,
  output logic       vic_write_db,
  output logic       ls245_data_dir,
  output logic       vic_capture,
  output logic       reg_wr_strobe,
  output logic       stolen
`ifdef BUS_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] stolen_count
`endif
);

  localparam logic [3:0] RAS_H = 4'(RAS_FALL);
  localparam logic [3:0] MUX_H = 4'(MUX_COL);
  localparam logic [3:0] CAS_H = 4'(CAS_FALL);
  localparam logic [3:0] CAP_H = 4'(CAPTURE);

  phase_t     phase_n;
  logic [3:0] h_n;
  logic       high_n;
  logic       vic_half_n;
  logic       phase_zero;
  logic       rd_pend;

  // Outputs are decoded from the upcoming phase so they line up with the phase value
  assign phase_n    = phase + 5'd1;
  assign h_n        = phase_n[3:0];
  assign high_n     = phase_n[4];
  assign vic_half_n = !high_n || stolen;
  assign phase_zero = (phase_n == 5'd0);

  ba_aec_arbiter #(
    .BA_LEAD(BA_LEAD)
  ) u_arbiter (
    .clk_dot4x (clk_dot4x),
    .rst       (rst),
    .phase_zero(phase_zero),
    .dma_req   (dma_req),
    .ba        (ba),
    .stolen    (stolen)
  );

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      phase          <= '0;
      clk_phi        <= 1'b0;
      aec            <= 1'b0;
      ras            <= 1'b1;
      cas            <= 1'b1;
      addr_mux       <= 1'b0;
      vic_write_ab   <= 1'b0;
      vic_write_db   <= 1'b0;
      ls245_data_dir <= 1'b0;
      vic_capture    <= 1'b0;
      reg_wr_strobe  <= 1'b0;
      rd_pend        <= 1'b0;
    end else begin
      phase        <= phase_n;
      clk_phi      <= high_n;
      aec          <= high_n && !stolen;
      ras          <= !(h_n >= RAS_H);
      cas          <= !(h_n >= CAS_H);
      addr_mux     <= vic_half_n && (h_n >= MUX_H);
      vic_write_ab <= vic_half_n && (h_n >= 4'd1) && (h_n <= 4'd14);
      vic_capture  <= vic_half_n && (h_n == CAP_H);

      // CPU register access is only honoured in a CPU-owned phi-high half
      if (phase == REG_RD_SAMPLE) begin
        rd_pend <= !ce && rw && !stolen;
      end
      if (phase_n == REG_RD_START && rd_pend) begin
        vic_write_db   <= 1'b1;
        ls245_data_dir <= 1'b1;
      end else if (phase_n == 5'd0) begin
        vic_write_db   <= 1'b0;
        ls245_data_dir <= 1'b0;
      end
      reg_wr_strobe <= (phase == REG_WR_SAMPLE) && !ce && !rw && !stolen;
    end
  end

`ifdef BUS_STATS_EN
  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      stolen_count <= '0;
    end else if (stats_clr) begin
      stolen_count <= '0;
    end else if (phase_n == 5'd16 && stolen && stolen_count != 16'hFFFF) begin
      stolen_count <= stolen_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer; stats checks compile in with BUS_STATS_EN.
module tb_bus_cycle_sequencer;

  logic       clk_dot4x;
  logic       rst;
  logic       dma_req;
  logic       ce;
  logic       rw;
  logic       clk_phi;
  logic [4:0] phase;
  logic       ba;
  logic       aec;
  logic       ras;
  logic       cas;
  logic       addr_mux;
  logic       vic_write_ab;
  logic       vic_write_db;
  logic       ls245_data_dir;
  logic       vic_capture;
  logic       reg_wr_strobe;
  logic       stolen;
`ifdef BUS_STATS_EN
  logic        stats_clr;
  logic [15:0] stolen_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bus_cycle_sequencer dut (
    .clk_dot4x     (clk_dot4x),
    .rst           (rst),
    .dma_req       (dma_req),
    .ce            (ce),
    .rw            (rw),
    .clk_phi       (clk_phi),
    .phase         (phase),
    .ba            (ba),
    .aec           (aec),
    .ras           (ras),
    .cas           (cas),
    .addr_mux      (addr_mux),
    .vic_write_ab  (vic_write_ab),
    .vic_write_db  (vic_write_db),
    .ls245_data_dir(ls245_data_dir),
    .vic_capture   (vic_capture),
    .reg_wr_strobe (reg_wr_strobe),
    .stolen        (stolen)
`ifdef BUS_STATS_EN
    ,
    .stats_clr     (stats_clr),
    .stolen_count  (stolen_count)
`endif
  );

  initial clk_dot4x = 1'b0;
  always #5 clk_dot4x = ~clk_dot4x;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (phase != 5'(p) && n < 64) begin
      @(negedge clk_dot4x);
      n++;
    end
    check($sformatf("sync_phase%0d", p), 32'(phase), 32'(p));
  endtask

  // One phi cycle from phase 0, checking every output each tick.
  task automatic run_cycle(input bit exp_st, input bit exp_ba,
                           input bit cyc_ce, input bit cyc_rw, input bit next_req);
    bit rd, wr, hi, vic;
    int h;
    wait_phase(0);
    ce = cyc_ce;
    rw = cyc_rw;
    rd = !cyc_ce && cyc_rw && !exp_st;
    wr = !cyc_ce && !cyc_rw && !exp_st;
    for (int p = 0; p < 32; p++) begin
      hi  = (p >= 16);
      h   = p % 16;
      vic = !hi || exp_st;
      check($sformatf("phase@%0d", p), 32'(phase), 32'(p));
      check($sformatf("clk_phi@%0d", p), 32'(clk_phi), 32'(hi));
      check($sformatf("aec@%0d", p), 32'(aec), 32'(hi && !exp_st));
      check($sformatf("ras@%0d", p), 32'(ras), 32'(h < 4));
      check($sformatf("cas@%0d", p), 32'(cas), 32'(h < 7));
      check($sformatf("vic_write_ab@%0d", p), 32'(vic_write_ab), 32'(vic && h >= 1 && h <= 14));
      check($sformatf("vic_capture@%0d", p), 32'(vic_capture), 32'(vic && h == 13));
      if (vic) check($sformatf("addr_mux@%0d", p), 32'(addr_mux), 32'(h >= 6));
      check($sformatf("vic_write_db@%0d", p), 32'(vic_write_db), 32'(rd && p >= 24));
      check($sformatf("ls245_dir@%0d", p), 32'(ls245_data_dir), 32'(rd && p >= 24));
      check($sformatf("reg_wr_strobe@%0d", p), 32'(reg_wr_strobe), 32'(wr && p == 29));
      check($sformatf("ba@%0d", p), 32'(ba), 32'(exp_ba));
      check($sformatf("stolen@%0d", p), 32'(stolen), 32'(exp_st));
      if (p == 20) dma_req = next_req;
      @(negedge clk_dot4x);
    end
  endtask

  initial begin
    rst     = 1'b1;
    dma_req = 1'b0;
    ce      = 1'b1;
    rw      = 1'b1;
`ifdef BUS_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(negedge clk_dot4x);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_clk_phi", 32'(clk_phi), 32'd0);
    check("rst_ba", 32'(ba), 32'd1);
    check("rst_aec", 32'(aec), 32'd0);
    check("rst_ras", 32'(ras), 32'd1);
    check("rst_cas", 32'(cas), 32'd1);
    check("rst_addr_mux", 32'(addr_mux), 32'd0);
    check("rst_vic_write_ab", 32'(vic_write_ab), 32'd0);
    check("rst_vic_write_db", 32'(vic_write_db), 32'd0);
    check("rst_ls245_dir", 32'(ls245_data_dir), 32'd0);
    check("rst_vic_capture", 32'(vic_capture), 32'd0);
    check("rst_reg_wr_strobe", 32'(reg_wr_strobe), 32'd0);
    check("rst_stolen", 32'(stolen), 32'd0);
    rst = 1'b0;

    // idle, register read, register write
    run_cycle(0, 1, 1, 1, 0);
    run_cycle(0, 1, 1, 1, 0);
    run_cycle(0, 1, 0, 1, 0);
    run_cycle(0, 1, 0, 0, 0);
    run_cycle(0, 1, 1, 1, 0);

    // DMA request alongside CPU accesses; stolen half ignores ce
    run_cycle(0, 1, 1, 1, 1);
    run_cycle(0, 0, 0, 1, 1);
    run_cycle(0, 0, 0, 0, 1);
    run_cycle(0, 0, 1, 1, 1);
    run_cycle(1, 0, 0, 1, 0);
    run_cycle(0, 1, 1, 1, 0);

    // single-cycle request pulse never steals
    run_cycle(0, 1, 1, 1, 1);
    run_cycle(0, 0, 1, 1, 0);
    run_cycle(0, 1, 1, 1, 0);
    run_cycle(0, 1, 1, 1, 0);

`ifdef BUS_STATS_EN
    stats_clr = 1'b1;
    @(negedge clk_dot4x);
    stats_clr = 1'b0;
    check("stats_clr_first", 32'(stolen_count), 32'd0);
`endif

    // five consecutive stolen cycles
    run_cycle(0, 1, 1, 1, 1);
    run_cycle(0, 0, 1, 1, 1);
    run_cycle(0, 0, 1, 1, 1);
    run_cycle(0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) run_cycle(1, 0, 1, 1, (i < 4));
    run_cycle(0, 1, 1, 1, 0);

`ifdef BUS_STATS_EN
    check("stolen_count_5", 32'(stolen_count), 32'd5);
    stats_clr = 1'b1;
    @(negedge clk_dot4x);
    stats_clr = 1'b0;
    check("stolen_count_clr", 32'(stolen_count), 32'd0);
`endif

    // reset asserted mid register read
    wait_phase(0);
    ce = 1'b0;
    rw = 1'b1;
    wait_phase(25);
    check("pre_rst_vic_write_db", 32'(vic_write_db), 32'd1);
    check("pre_rst_cas", 32'(cas), 32'd0);
    check("pre_rst_ras", 32'(ras), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_vic_write_db", 32'(vic_write_db), 32'd0);
    check("mid_rst_ls245_dir", 32'(ls245_data_dir), 32'd0);
    check("mid_rst_cas", 32'(cas), 32'd1);
    check("mid_rst_ras", 32'(ras), 32'd1);
    check("mid_rst_phase", 32'(phase), 32'd0);
    check("mid_rst_aec", 32'(aec), 32'd0);
    ce = 1'b1;
    @(negedge clk_dot4x);
    rst = 1'b0;
    check("post_rst_phase0", 32'(phase), 32'd0);
    @(negedge clk_dot4x);
    check("post_rst_phase1", 32'(phase), 32'd1);
    run_cycle(0, 1, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
